// File: rtl/div_mon_pkg.sv
// Shared types and default widths for the divider ratio monitor.
package div_mon_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned WIN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MEAS,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rise_edge_det.sv
// One-flop rising-edge detector with synchronous active-high reset.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/div_ratio_monitor.sv
// Measures rising-edge periods of a divided clock against an expected ratio.
// Optional high-time check is built when DUTY_CHECK_EN is defined.
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_in,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_ratio,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [WIN_W-1:0] num_periods,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIN_W-1:0] err_cnt,
  output logic [CNT_W-1:0] last_period,
  output logic             timeout,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic             rise_c;
  logic [CNT_W-1:0] exp_ratio_q, per_cnt_q;
  logic [WIN_W-1:0] num_q, idx_q;
  logic             cfg_bad_c, sat_c, last_c, duty_bad_c, period_bad_c;

  rise_edge_det u_rise (
    .clk    (clk_in),
    .rst    (rst),
    .d      (div_in),
    .rise_c (rise_c)
  );

  assign cfg_bad_c    = exp_ratio < CNT_W'(2);
  // A rise on the saturating cycle still closes a valid period.
  assign sat_c        = (per_cnt_q == CNT_MAX) && !rise_c;
  assign last_c       = (idx_q + WIN_W'(1)) == num_q;
  assign period_bad_c = (per_cnt_q != exp_ratio_q) || duty_bad_c;

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] exp_high_q, hi_cnt_q;

  // High-time counter; the rise cycle itself is the first high cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      exp_high_q <= '0;
      hi_cnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && start) exp_high_q <= exp_high;
      if (rise_c)                                hi_cnt_q <= CNT_W'(1);
      else if (div_in && hi_cnt_q != CNT_MAX)    hi_cnt_q <= hi_cnt_q + CNT_W'(1);
    end
  end

  assign duty_bad_c = hi_cnt_q != exp_high_q;
`else
  logic unused_exp_high;
  assign unused_exp_high = ^exp_high;
  assign duty_bad_c      = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                 state_d = cfg_bad_c ? ST_DONE : ST_SYNC;
      ST_SYNC: if (rise_c)                state_d = ST_MEAS;
               else if (sat_c)            state_d = ST_DONE;
      ST_MEAS: if (rise_c && last_c)      state_d = ST_DONE;
               else if (sat_c)            state_d = ST_DONE;
      ST_DONE:                            state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= '0;
      last_period <= '0;
      timeout     <= 1'b0;
      cfg_err     <= 1'b0;
      exp_ratio_q <= '0;
      num_q       <= '0;
      per_cnt_q   <= '0;
      idx_q       <= '0;
    end else begin
      done <= state_d == ST_DONE;
      busy <= (state_d == ST_SYNC) || (state_d == ST_MEAS);
      case (state_q)
        ST_IDLE: if (start) begin
          exp_ratio_q <= exp_ratio;
          num_q       <= (num_periods == '0) ? WIN_W'(1) : num_periods;
          err_cnt     <= '0;
          pass        <= 1'b0;
          timeout     <= 1'b0;
          cfg_err     <= cfg_bad_c;
          per_cnt_q   <= CNT_W'(1);
          idx_q       <= '0;
        end
        ST_SYNC: begin
          if (rise_c) begin
            per_cnt_q <= CNT_W'(1);
            idx_q     <= '0;
          end else if (sat_c) begin
            timeout   <= 1'b1;
          end else begin
            per_cnt_q <= per_cnt_q + CNT_W'(1);
          end
        end
        ST_MEAS: begin
          if (rise_c) begin
            last_period <= per_cnt_q;
            if (period_bad_c && err_cnt != ERR_MAX) err_cnt <= err_cnt + WIN_W'(1);
            per_cnt_q   <= CNT_W'(1);
            idx_q       <= idx_q + WIN_W'(1);
            if (last_c) pass <= (err_cnt == '0) && !period_bad_c;
          end else if (sat_c) begin
            timeout     <= 1'b1;
          end else begin
            per_cnt_q   <= per_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed table-driven bench for div_ratio_monitor.
module tb_div_ratio_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 8;
  localparam int          HIST  = 400;

  logic             clk_in = 1'b0;
  logic             rst, div_in, start;
  logic [CNT_W-1:0] exp_ratio, exp_high;
  logic [WIN_W-1:0] num_periods;
  logic             busy, done, pass, timeout, cfg_err;
  logic [WIN_W-1:0] err_cnt;
  logic [CNT_W-1:0] last_period;

  div_ratio_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .div_in      (div_in),
    .start       (start),
    .exp_ratio   (exp_ratio),
    .exp_high    (exp_high),
    .num_periods (num_periods),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_cnt     (err_cnt),
    .last_period (last_period),
    .timeout     (timeout),
    .cfg_err     (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Results captured by run()
  int done_c, d_pass, d_err, d_last, d_to, d_cfg, d_busy, busy1, after_done, after_pass;
  int err_hist [HIST];
  int busy_hist[HIST];
  int last_hist[HIST];

  typedef struct {
    int ratio; int high; int nper; int src_n; int src_hi; int start2_at;
    int exp_done; int exp_pass; int exp_err; int exp_last; int exp_to; int exp_cfg; int exp_busy1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start at cycle 0; source is low on cycles 0-1 and its first rise is at cycle 2.
  task automatic run(input int ratio, input int high, input int nper, input int src_n,
                     input int src_hi, input int rst_at, input int start2_at, input int max_c);
    done_c = -1; d_pass = -1; d_err = -1; d_last = -1; d_to = -1; d_cfg = -1; d_busy = -1;
    busy1 = -1; after_done = -1; after_pass = -1;
    for (int c = 0; c <= max_c; c++) begin
      @(negedge clk_in);
      err_hist[c]  = int'(err_cnt);
      busy_hist[c] = int'(busy);
      last_hist[c] = int'(last_period);
      if (c == 1) busy1 = int'(busy);
      if (done && done_c < 0) begin
        done_c = c; d_pass = int'(pass); d_err = int'(err_cnt); d_last = int'(last_period);
        d_to = int'(timeout); d_cfg = int'(cfg_err); d_busy = int'(busy);
      end else if (done_c >= 0 && c == done_c + 1) begin
        after_done = int'(done); after_pass = int'(pass);
        break;
      end
      rst         = (c == rst_at);
      start       = (c == 0) || (c == start2_at);
      exp_ratio   = (c == start2_at) ? CNT_W'(1) : CNT_W'(ratio);
      exp_high    = CNT_W'(high);
      num_periods = WIN_W'(nper);
      div_in      = (src_n > 0 && c >= 2) ? (((c - 2) % src_n) < src_hi) : 1'b0;
    end
    rst = 1'b0; start = 1'b0; div_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; div_in = 1'b0;
    exp_ratio = '0; exp_high = '0; num_periods = '0;

    //        ratio hi nper srcN srcHi st2 | done pass err last to cfg busy1
    vecs[0] = '{3, 0, 4, 3, 1, -1,   15, 1, 0, 3, 0, 0, 1};
    vecs[1] = '{4, 0, 4, 3, 1, -1,   15, 0, 4, 3, 0, 0, 1};
    vecs[2] = '{3, 0, 4, 0, 0, -1,  256, 0, 0, 3, 1, 0, 1};
    vecs[3] = '{1, 0, 4, 3, 1, -1,    1, 0, 0, 3, 0, 1, 0};
    vecs[4] = '{5, 0, 0, 5, 2, -1,    8, 1, 0, 5, 0, 0, 1};
    vecs[5] = '{2, 0, 3, 2, 1, -1,    9, 1, 0, 2, 0, 0, 1};
    vecs[6] = '{0, 0, 3, 2, 1, -1,    1, 0, 0, 2, 0, 1, 0};
`ifdef DUTY_CHECK_EN
    vecs[7] = '{3, 1, 2, 3, 2, -1,    9, 0, 2, 3, 0, 0, 1};
`else
    vecs[7] = '{3, 1, 2, 3, 2, -1,    9, 1, 0, 3, 0, 0, 1};
`endif
    vecs[8] = '{3, 0, 3, 4, 1, -1,   15, 0, 3, 4, 0, 0, 1};
    vecs[9] = '{3, 0, 4, 3, 1,  6,   15, 1, 0, 3, 0, 0, 1};

    repeat (3) @(negedge clk_in);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_last_period", int'(last_period), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    foreach (vecs[i]) begin
      run(vecs[i].ratio, vecs[i].high, vecs[i].nper, vecs[i].src_n, vecs[i].src_hi,
          -1, vecs[i].start2_at, 300);
      chk($sformatf("v%0d_done_cycle", i), done_c, vecs[i].exp_done);
      chk($sformatf("v%0d_pass", i), d_pass, vecs[i].exp_pass);
      chk($sformatf("v%0d_err_cnt", i), d_err, vecs[i].exp_err);
      chk($sformatf("v%0d_last_period", i), d_last, vecs[i].exp_last);
      chk($sformatf("v%0d_timeout", i), d_to, vecs[i].exp_to);
      chk($sformatf("v%0d_cfg_err", i), d_cfg, vecs[i].exp_cfg);
      chk($sformatf("v%0d_busy_after_start", i), busy1, vecs[i].exp_busy1);
      chk($sformatf("v%0d_busy_at_done", i), d_busy, 0);
      chk($sformatf("v%0d_done_one_cycle", i), after_done, 0);
      chk($sformatf("v%0d_pass_held", i), after_pass, vecs[i].exp_pass);
    end

    // Per-period update timing: ratio-5 source against exp_ratio 4, rises at 2,7,12,17,22.
    run(4, 0, 4, 5, 1, -1, -1, 60);
    chk("upd_err_before", err_hist[7], 0);
    chk("upd_err_after", err_hist[8], 1);
    chk("upd_last_after", last_hist[8], 5);
    chk("upd_err_second", err_hist[13], 2);
    chk("upd_done_cycle", done_c, 23);
    chk("upd_err_final", d_err, 4);

    // Reset in MEAS after one mismatching period; nothing may restart afterwards.
    run(4, 0, 4, 3, 1, 7, -1, 40);
    chk("mrst_err_pre", err_hist[7], 1);
    chk("mrst_busy_pre", busy_hist[7], 1);
    chk("mrst_err_post", err_hist[8], 0);
    chk("mrst_busy_post", busy_hist[8], 0);
    chk("mrst_last_post", last_hist[8], 0);
    chk("mrst_busy_late", busy_hist[30], 0);
    chk("mrst_no_done", done_c, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
